sng_bank: RTL and testbench
===========================

Name: sng_bank

Overview:
- Stochastic number generator bank that sits directly upstream of `network`.
- Accepts one sample: N_INPUTS unsigned values, each in the range 0..LENGTH.
- Converts each value to a unipolar bitstream using one full-period 256-state LFSR per channel and a comparator.
- Drives `network`'s compute window: compute high for exactly LENGTH cycles, then one low gap cycle in which `network` publishes its output.

Parameters:
- N_INPUTS, 2, number of channels / bitstreams.
- WIDTH, 8, LFSR and comparator width. LENGTH must equal 2**WIDTH.
- LENGTH, 256, compute window length in cycles.
- SEED, 8'b10001101, base LFSR seed. Channel k seed = (SEED + 37*k) mod 256.

Ports:
- clk  in  1  clock, rising edge.
- n_rst  in  1  synchronous, active-low reset.
- in_valid  in  1  sample offered.
- in_ready  out  1  block can accept a sample this cycle.
- in_value  in  N_INPUTS*(WIDTH+1)  channel k occupies bits [k*(WIDTH+1) +: WIDTH+1], unsigned.
- compute  out  1  window active; connects to `network.compute`.
- bits  out  N_INPUTS  one stochastic bit per channel; valid only while compute=1.
- window_done  out  1  single-cycle pulse in the gap cycle after each window.

Behaviour:
- Reset: synchronous, active-low; one clock clears all state, regardless of FSM state.
  - While n_rst=0: compute=0, bits=0, window_done=0, in_ready=0.
  - Internal state: FSM=IDLE, counter=0, LFSRs=seeds, latched values=0.
  - First cycle after release: in_ready=1.
- FSM states: IDLE, RUN, GAP.
- IDLE:
  - in_ready=1, compute=0, bits=0.
  - Acceptance occurs when in_valid & in_ready.
  - On acceptance: latch in_value, saturating any channel value >LENGTH to LENGTH. Load each LFSR with its seed, clear the counter, go to RUN.
- RUN:
  - compute=1, in_ready=0; in_valid is ignored.
  - bits[k] = (lfsr_k < value_k), combinational from registered state.
  - Every cycle: all LFSRs advance, counter increments.
  - When counter==LENGTH-1, the next state is GAP.
- GAP (exactly one cycle):
  - compute=0, bits=0, window_done=1.
  - in_ready=1: acceptance in GAP loads a new sample and goes directly to RUN (back-to-back windows). Otherwise go to IDLE.
- Latency: for acceptance at edge t, compute is high for cycles t+1..t+LENGTH and window_done is high in cycle t+LENGTH+1.
- Sample period: LENGTH+1 cycles minimum.
- LFSR (per channel, de Bruijn-extended Fibonacci, x^8+x^6+x^5+x^4+1):
  - next = {s[6:0], fb}.
  - fb = s[7]^s[5]^s[4]^s[3]^(s[6:0]==7'd0).
  - Period is exactly 256 and includes state 0, so each window visits every state once.
  - Consequence: the number of ones on bits[k] per window equals value_k exactly.
  - Value 0 gives all zeros; value 256 gives all ones.
- Seeds: channels start at distinct seeds so streams are decorrelated. Counts per window are unaffected.
- Reset mid-RUN: the window aborts in the same clock. No window_done is produced, and compute falls on the cycle reset is sampled.
- in_valid with in_ready=0: no effect; the value is not latched.
- Changes to in_value during RUN: no effect on bits.

Test Plan:
- Reset, then offer {ch0=128, ch1=64}.
  - in_ready deasserts the cycle after acceptance.
  - compute high exactly 256 cycles.
  - Ones counted: ch0=128, ch1=64.
  - window_done pulses once, in the cycle after compute falls.
- Offer {0, 256} -> bits[0]=0 and bits[1]=1 on every compute cycle. Counts 0 and 256.
- Offer {300, 511} -> saturation; both channels count 256.
- Hold in_valid high with samples {107,89} then {103,83}.
  - Second sample accepted in the GAP cycle.
  - compute low for exactly 1 cycle between windows.
  - Counts 107/89, then 103/83.
- Assert n_rst=0 for 1 cycle at window cycle 100.
  - Next cycle: compute=0, no window_done, in_ready=1 after release.
  - A new sample {50,200} then counts exactly 50/200.
- LFSR check: run 257 cycles from SEED. All 256 states are distinct and state 257 equals SEED. Channel-1 first state = 8'b10110010 (SEED+37).

Source files
------------

// File: rtl/sng_bank.sv
// Purpose: stochastic number generator bank; one LFSR + comparator per channel feeding the network compute window.
// Latency: acceptance at edge t -> compute high cycles t+1..t+LENGTH, window_done pulse in cycle t+LENGTH+1.
// Backpressure: in_ready only in IDLE/GAP; one sample per LENGTH+1 cycles, in_valid ignored while running.
module sng_bank #(
    parameter int               N_INPUTS = 2,
    parameter int               WIDTH    = 8,
    parameter int               LENGTH   = 256,
    parameter logic [WIDTH-1:0] SEED     = 8'b10001101
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N_INPUTS*(WIDTH+1)-1:0] in_value,
    output logic                         compute,
    output logic [N_INPUTS-1:0]          bits,
    output logic                         window_done
);

    localparam int             CW      = $clog2(LENGTH);
    localparam logic [WIDTH:0] MAX_VAL = (WIDTH+1)'(LENGTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        GAP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] lfsr    [N_INPUTS];
    logic [WIDTH:0]   value   [N_INPUTS];
    logic [WIDTH:0]   sat_in  [N_INPUTS];
    logic             accept;
    logic             last;

    // De Bruijn-extended Fibonacci LFSR (x^8+x^6+x^5+x^4+1): the all-zero-tail
    // term splices state 0 into the cycle, giving a full 256-state period.
    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        logic fb;
        fb = s[7] ^ s[5] ^ s[4] ^ s[3] ^ (s[WIDTH-2:0] == '0);
        return {s[WIDTH-2:0], fb};
    endfunction

    // Per-channel seed, offset so the streams are decorrelated.
    function automatic logic [WIDTH-1:0] seed_of(input int k);
        return WIDTH'(int'(SEED) + 37 * k);
    endfunction

    assign last = (count == CW'(LENGTH - 1));

    // Saturate each incoming channel value to LENGTH.
    always_comb begin
        for (int k = 0; k < N_INPUTS; k++) begin
            sat_in[k] = in_value[k*(WIDTH+1) +: WIDTH+1];
            if (sat_in[k] > MAX_VAL) sat_in[k] = MAX_VAL;
        end
    end

    // Next-state and control outputs; everything forced low while reset is held.
    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        compute     = 1'b0;
        window_done = 1'b0;
        accept      = 1'b0;
        if (n_rst) begin
            case (state)
                IDLE: begin
                    in_ready = 1'b1;
                    accept   = in_valid;
                    if (in_valid) state_nxt = RUN;
                end
                RUN: begin
                    compute = 1'b1;
                    if (last) state_nxt = GAP;
                end
                GAP: begin
                    in_ready    = 1'b1;
                    window_done = 1'b1;
                    accept      = in_valid;
                    state_nxt   = in_valid ? RUN : IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Comparator per channel; bits are only meaningful inside the window.
    always_comb begin
        bits = '0;
        for (int k = 0; k < N_INPUTS; k++) begin
            if (compute) bits[k] = ({1'b0, lfsr[k]} < value[k]);
        end
    end

    // State, counter, LFSRs and latched values.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= IDLE;
            count <= '0;
            for (int k = 0; k < N_INPUTS; k++) begin
                lfsr[k]  <= seed_of(k);
                value[k] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (accept) begin
                count <= '0;
                for (int k = 0; k < N_INPUTS; k++) begin
                    lfsr[k]  <= seed_of(k);
                    value[k] <= sat_in[k];
                end
            end else if (state == RUN) begin
                count <= count + 1'b1;
                for (int k = 0; k < N_INPUTS; k++) begin
                    lfsr[k] <= lfsr_step(lfsr[k]);
                end
            end
        end
    end

endmodule

// File: tb/tb_sng_bank.sv
// Bench for sng_bank: directed and random samples, ones-count and per-cycle bit checks.
// Reference: counts from saturated values, bit pattern from the documented LFSR walk.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_sng_bank;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] in_value;
    logic        compute;
    logic [1:0]  bits;
    logic        window_done;

    int checks = 0;
    int errors = 0;

    sng_bank dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_value    (in_value),
        .compute     (compute),
        .bits        (bits),
        .window_done (window_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 256) ? 256 : v;
    endfunction

    function automatic logic [7:0] step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3] ^ (s[6:0] == 7'd0)};
    endfunction

    // Offer a sample from a falling edge; returns just after the accepting rising edge.
    task automatic accept(input int a, input int b);
        int n;
        in_valid = 1'b1;
        in_value = {9'(b), 9'(a)};
        n = 0;
        while (in_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 32'(in_ready), 1);
        @(posedge clk);
    endtask

    // Observe one full window plus its gap cycle, assuming acceptance at the last rising edge.
    task automatic window(input int a, input int b, input bit keep, input int na, input int nb);
        logic [7:0] s0;
        logic [7:0] s1;
        int e0, e1, ones0, ones1, bad, ctrl_bad;
        e0 = sat(a);
        e1 = sat(b);
        s0 = 8'd141;
        s1 = 8'd178;
        ones0 = 0; ones1 = 0; bad = 0; ctrl_bad = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (i == 0) begin
                if (keep) in_value = {9'(nb), 9'(na)};
                else begin
                    in_valid = 1'b0;
                    in_value = 18'($urandom);
                end
            end
            if (compute !== 1'b1 || in_ready !== 1'b0 || window_done !== 1'b0) ctrl_bad++;
            if (bits[0] !== (s0 < e0)) bad++;
            if (bits[1] !== (s1 < e1)) bad++;
            ones0 += int'(bits[0]);
            ones1 += int'(bits[1]);
            s0 = step(s0);
            s1 = step(s1);
        end
        chk("run_ctrl", ctrl_bad, 0);
        chk("bit_pattern", bad, 0);
        chk("ones_ch0", ones0, e0);
        chk("ones_ch1", ones1, e1);
        @(negedge clk);
        chk("gap_compute", 32'(compute), 0);
        chk("gap_done", 32'(window_done), 1);
        chk("gap_ready", 32'(in_ready), 1);
        chk("gap_bits", 32'(bits), 0);
        if (keep) begin
            @(posedge clk);
        end else begin
            @(negedge clk);
            chk("idle_done", 32'(window_done), 0);
            chk("idle_ready", 32'(in_ready), 1);
            chk("idle_compute", 32'(compute), 0);
        end
    endtask

    initial begin
        int busy;
        int ra, rb;
        n_rst    = 1'b0;
        in_valid = 1'b0;
        in_value = '0;
        repeat (3) @(negedge clk);
        chk("rst_compute", 32'(compute), 0);
        chk("rst_ready", 32'(in_ready), 0);
        chk("rst_bits", 32'(bits), 0);
        chk("rst_done", 32'(window_done), 0);
        n_rst = 1'b1;
        #1;
        chk("rel_ready", 32'(in_ready), 1);
        @(negedge clk);

        // Basic window, extremes, saturation, seed-sensitive first bits.
        accept(128, 64);  window(128, 64, 1'b0, 0, 0);
        accept(0, 256);   window(0, 256, 1'b0, 0, 0);
        accept(300, 511); window(300, 511, 1'b0, 0, 0);
        accept(142, 179); window(142, 179, 1'b0, 0, 0);
        accept(141, 178); window(141, 178, 1'b0, 0, 0);

        // Back-to-back windows with in_valid held high.
        accept(107, 89);  window(107, 89, 1'b1, 103, 83);
        window(103, 83, 1'b0, 0, 0);

        // Reset in the middle of a window.
        accept(200, 30);
        in_valid = 1'b0;
        repeat (100) @(negedge clk);
        n_rst = 1'b0;
        #1;
        chk("mid_rst_compute", 32'(compute), 0);
        chk("mid_rst_ready", 32'(in_ready), 0);
        chk("mid_rst_bits", 32'(bits), 0);
        chk("mid_rst_done", 32'(window_done), 0);
        @(negedge clk);
        n_rst = 1'b1;
        #1;
        chk("post_rst_compute", 32'(compute), 0);
        chk("post_rst_ready", 32'(in_ready), 1);
        chk("post_rst_done", 32'(window_done), 0);
        busy = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (compute !== 1'b0 || window_done !== 1'b0) busy++;
        end
        chk("post_rst_quiet", busy, 0);
        accept(50, 200);  window(50, 200, 1'b0, 0, 0);

        // Random samples across the full input range, including saturation.
        for (int r = 0; r < 4; r++) begin
            ra = int'($urandom_range(0, 511));
            rb = int'($urandom_range(0, 511));
            accept(ra, rb);
            window(ra, rb, 1'b0, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
